// File: rtl/load_store_unit_pkg.sv
// Shared loopyV data types: access sizes and LSU FSM states,
// plus the byte-count and byte-mask helpers used by the load/store unit.
package loopyV_data_types;

    typedef enum logic [1:0] {
        MEM_SIZE_B = 2'd0,
        MEM_SIZE_H = 2'd1,
        MEM_SIZE_W = 2'd2
    } memSizeType;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ0 = 3'd1,
        RSP0 = 3'd2,
        REQ1 = 3'd3,
        RSP1 = 3'd4,
        DONE = 3'd5
    } lsuStateType;

    // Encoding 3 behaves as a full word.
    function automatic logic [2:0] sizeBytes(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: return 3'd1;
            MEM_SIZE_H: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] sizeMask(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: return 4'b0001;
            MEM_SIZE_H: return 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane shifter: READ=0 spreads store data/enables over two
// word lanes, READ=1 extracts and extends load bytes from a {high,low} pair.
module lsu_align
    import loopyV_data_types::*;
#(
    parameter bit READ = 1'b0
)
(
    input  logic [63:0] dataIn,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    output logic [63:0] dataOut,
    output logic [7:0]  beOut
);

    logic [63:0] shifted;
    logic [31:0] ext;

    always_comb begin
        beOut = {4'b0000, sizeMask(size)} << off;
        if (READ) begin
            shifted = dataIn >> {off, 3'b000};
        end else begin
            shifted = dataIn << {off, 3'b000};
        end
        case (size)
            MEM_SIZE_B: ext = {{24{~isUnsigned & shifted[7]}}, shifted[7:0]};
            MEM_SIZE_H: ext = {{16{~isUnsigned & shifted[15]}}, shifted[15:0]};
            default:    ext = shifted[31:0];
        endcase
        dataOut = READ ? {32'h0, ext} : shifted;
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns one CPU access into one or two word-wide
// bus transfers, stalling the pipeline until the access has completed.
module load_store_unit
    import loopyV_data_types::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        memReq,
    input  logic        memWe,
    input  logic [31:0] memAddr,
    input  logic [31:0] memWData,
    input  logic [1:0]  memSize,
    input  logic        memUnsigned,
    output logic        stall,
    output logic [31:0] dmLoadData,
    output logic        loadDone,
    output logic        misalignErr,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [3:0]  busBe,
    output logic [31:0] busWData,
    input  logic        busGnt,
    input  logic        busRValid,
    input  logic [31:0] busRData
);

    lsuStateType state;
    logic [31:0] addrQ;
    logic [31:0] wdataQ;
    logic [31:0] lowBuf;
    logic [31:0] highBuf;
    logic [1:0]  sizeQ;
    logic        weQ;
    logic        unsQ;
    logic        crossQ;

    logic        reqCross;
    logic        reqReject;
    logic [63:0] wrLanes;
    logic [7:0]  wrBe;
    logic [31:0] rdWord;
    logic [31:0] unusedRdHigh;
    logic [7:0]  unusedRdBe;

    assign reqCross  = ({1'b0, memAddr[1:0]} + sizeBytes(memSize)) > 3'd4;
    assign reqReject = reqCross && !SPLIT_MISALIGNED;
    assign stall     = (state != IDLE) || (memReq && !reqReject);

    lsu_align #(.READ(1'b0)) wrAlign (
        .dataIn     ({32'h0, wdataQ}),
        .off        (addrQ[1:0]),
        .size       (sizeQ),
        .isUnsigned (unsQ),
        .dataOut    (wrLanes),
        .beOut      (wrBe)
    );

    lsu_align #(.READ(1'b1)) rdAlign (
        .dataIn     ({highBuf, lowBuf}),
        .off        (addrQ[1:0]),
        .size       (sizeQ),
        .isUnsigned (unsQ),
        .dataOut    ({unusedRdHigh, rdWord}),
        .beOut      (unusedRdBe)
    );

    // Bus outputs are zero whenever no request is being presented.
    always_comb begin
        busReq   = 1'b0;
        busWe    = 1'b0;
        busAddr  = 32'h0;
        busBe    = 4'h0;
        busWData = 32'h0;
        if (state == REQ0) begin
            busReq   = 1'b1;
            busWe    = weQ;
            busAddr  = {addrQ[31:2], 2'b00};
            busBe    = wrBe[3:0];
            busWData = wrLanes[31:0];
        end else if (state == REQ1) begin
            busReq   = 1'b1;
            busWe    = weQ;
            busAddr  = {addrQ[31:2], 2'b00} + 32'd4;
            busBe    = wrBe[7:4];
            busWData = wrLanes[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addrQ       <= 32'h0;
            wdataQ      <= 32'h0;
            lowBuf      <= 32'h0;
            highBuf     <= 32'h0;
            sizeQ       <= 2'd0;
            weQ         <= 1'b0;
            unsQ        <= 1'b0;
            crossQ      <= 1'b0;
            dmLoadData  <= 32'h0;
            loadDone    <= 1'b0;
            misalignErr <= 1'b0;
        end else begin
            loadDone    <= 1'b0;
            misalignErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (memReq) begin
                        if (reqReject) begin
                            misalignErr <= 1'b1;
                        end else begin
                            addrQ  <= memAddr;
                            wdataQ <= memWData;
                            sizeQ  <= memSize;
                            weQ    <= memWe;
                            unsQ   <= memUnsigned;
                            crossQ <= reqCross;
                            state  <= REQ0;
                        end
                    end
                end
                REQ0: if (busGnt) state <= RSP0;
                RSP0: begin
                    if (busRValid) begin
                        lowBuf <= busRData;
                        state  <= crossQ ? REQ1 : DONE;
                    end
                end
                REQ1: if (busGnt) state <= RSP1;
                RSP1: begin
                    if (busRValid) begin
                        highBuf <= busRData;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // Stores leave the previous load result visible to WB.
                    if (!weQ) begin
                        dmLoadData <= rdWord;
                        loadDone   <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of accesses checked through a bus
// scoreboard and a load-result queue, plus misalign and mid-transfer reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReq;
    logic        nsMemReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [1:0]  memSize;
    logic        memUnsigned;
    logic        busGnt;
    logic        busRValid;
    logic [31:0] busRData;

    logic        stall, loadDone, misalignErr, busReq, busWe;
    logic [31:0] dmLoadData, busAddr, busWData;
    logic [3:0]  busBe;

    logic        nsStall, nsLoadDone, nsMisalignErr, nsBusReq, nsBusWe;
    logic [31:0] nsLoadData, nsBusAddr, nsBusWData;
    logic [3:0]  nsBusBe;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rdLo;
        logic [31:0] rdHi;
        int          gntWait;
        int          rspWait;
        int          nXfer;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] expLoad;
        int          expLat;
    } vecT;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          gntWait;
        int          rspWait;
    } xferT;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } loadT;

    vecT         vecs[13];
    vecT         lastVec;
    xferT        xferQ[$];
    loadT        loadQ[$];
    xferT        curX;
    loadT        curL;
    int          assertCount = 0;
    int          failCount = 0;
    int          cyc = 0;
    int          acceptCyc = 0;
    logic [31:0] lastLoad = 32'h0;
    logic        responderOn = 1'b0;
    logic        rspPending = 1'b0;
    logic        gntArmed = 1'b0;
    int          gntCnt = 0;
    int          rspCnt = 0;
    logic [31:0] curRData = 32'h0;

    load_store_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memWData(memWData), .memSize(memSize), .memUnsigned(memUnsigned),
        .stall(stall), .dmLoadData(dmLoadData), .loadDone(loadDone), .misalignErr(misalignErr),
        .busReq(busReq), .busWe(busWe), .busAddr(busAddr), .busBe(busBe), .busWData(busWData),
        .busGnt(busGnt), .busRValid(busRValid), .busRData(busRData)
    );

    load_store_unit #(.SPLIT_MISALIGNED(1'b0)) dutNs (
        .clk(clk), .rst(rst), .memReq(nsMemReq), .memWe(memWe), .memAddr(memAddr),
        .memWData(memWData), .memSize(memSize), .memUnsigned(memUnsigned),
        .stall(nsStall), .dmLoadData(nsLoadData), .loadDone(nsLoadDone), .misalignErr(nsMisalignErr),
        .busReq(nsBusReq), .busWe(nsBusWe), .busAddr(nsBusAddr), .busBe(nsBusBe), .busWData(nsBusWData),
        .busGnt(busGnt), .busRValid(busRValid), .busRData(busRData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Bus slave: grants after gntWait cycles, answers rspWait cycles later,
    // and checks each granted transfer against the scoreboard.
    always begin
        @(negedge clk);
        if (responderOn) begin
            busRValid = 1'b0;
            busRData  = 32'hBAD0BAD0;
            if (rspPending) begin
                if (rspCnt > 0) begin
                    rspCnt--;
                end else begin
                    busRValid  = 1'b1;
                    busRData   = curRData;
                    rspPending = 1'b0;
                end
            end else if (busReq) begin
                if (xferQ.size() == 0) begin
                    checkOutput("unexpectedBusReq", {31'h0, busReq}, 32'h0);
                    busGnt = 1'b1;
                end else begin
                    if (!gntArmed) begin
                        gntCnt   = xferQ[0].gntWait;
                        gntArmed = 1'b1;
                    end
                    if (gntCnt > 0) begin
                        busGnt = 1'b0;
                        gntCnt--;
                    end else begin
                        busGnt = 1'b1;
                        curX = xferQ.pop_front();
                        checkOutput("busWe", {31'h0, busWe}, {31'h0, curX.we});
                        checkOutput("busAddr", busAddr, curX.addr);
                        checkOutput("busBe", {28'h0, busBe}, {28'h0, curX.be});
                        checkOutput("busWData", busWData, curX.wd);
                        curRData   = curX.rdata;
                        rspCnt     = curX.rspWait;
                        rspPending = 1'b1;
                        gntArmed   = 1'b0;
                    end
                end
            end else begin
                busGnt = 1'b1;
            end
        end
    end

    // Load-result monitor for the splitting DUT.
    always @(negedge clk) begin
        if (loadDone) begin
            if (loadQ.size() == 0) begin
                checkOutput("unexpectedLoadDone", {31'h0, loadDone}, 32'h0);
            end else begin
                curL = loadQ.pop_front();
                checkOutput("dmLoadData", dmLoadData, curL.data);
                if (curL.lat >= 0) checkOutput("loadLatency", cyc - acceptCyc, curL.lat);
            end
        end
        if (misalignErr) checkOutput("unexpectedMisalign", {31'h0, misalignErr}, 32'h0);
        if (nsBusReq) checkOutput("nsUnexpectedBusReq", {31'h0, nsBusReq}, 32'h0);
    end

    task automatic applyStimulus(input vecT v);
        xferT        x;
        loadT        l;
        logic [31:0] a0;
        int          waited;
        a0 = {v.addr[31:2], 2'b00};
        x = '{v.we, a0, v.be0, v.wd0, v.rdLo, v.gntWait, v.rspWait};
        xferQ.push_back(x);
        if (v.nXfer == 2) begin
            x = '{v.we, a0 + 32'd4, v.be1, v.wd1, v.rdHi, v.gntWait, v.rspWait};
            xferQ.push_back(x);
        end
        if (!v.we) begin
            l = '{v.expLoad, v.expLat};
            loadQ.push_back(l);
            lastLoad = v.expLoad;
        end
        @(negedge clk);
        memReq      = 1'b1;
        memWe       = v.we;
        memAddr     = v.addr;
        memWData    = v.wdata;
        memSize     = v.size;
        memUnsigned = v.uns;
        #1 checkOutput("stallOnReq", {31'h0, stall}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        acceptCyc = cyc;
        memReq    = 1'b0;
        waited    = 0;
        while (stall && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (stall) begin
            checkOutput("completionTimeout", {31'h0, stall}, 32'h0);
            xferQ.delete();
            loadQ.delete();
        end
        @(negedge clk);
        checkOutput("xferLeft", xferQ.size(), 32'h0);
        checkOutput("loadLeft", loadQ.size(), 32'h0);
        checkOutput("holdLoadData", dmLoadData, lastLoad);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; memReq = 1'b0; nsMemReq = 1'b0; memWe = 1'b0; memAddr = 32'h0;
        memWData = 32'h0; memSize = 2'd0; memUnsigned = 1'b0;
        busGnt = 1'b1; busRValid = 1'b0; busRData = 32'h0;

        //          we    addr          wdata         sz    uns   rdLo          rdHi          gW rW nX be0    wd0           be1    wd1           expLoad       lat
        vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        0, 0, 1, 4'hF, 32'h0,        4'h0, 32'h0,        32'hDEADBEEF, 3};
        vecs[1]  = '{1'b0, 32'h0000_0103, 32'h0,        2'd0, 1'b0, 32'h80112233, 32'h0,        0, 0, 1, 4'h8, 32'h0,        4'h0, 32'h0,        32'hFFFFFF80, 3};
        vecs[2]  = '{1'b0, 32'h0000_0103, 32'h0,        2'd0, 1'b1, 32'h80112233, 32'h0,        0, 0, 1, 4'h8, 32'h0,        4'h0, 32'h0,        32'h00000080, 3};
        vecs[3]  = '{1'b1, 32'h0000_0202, 32'hAABBCCDD, 2'd2, 1'b0, 32'h0,        32'h0,        0, 0, 2, 4'hC, 32'hCCDD0000, 4'h3, 32'h0000AABB, 32'h0,        -1};
        vecs[4]  = '{1'b0, 32'h0000_0002, 32'h0,        2'd1, 1'b0, 32'h80011234, 32'h0,        0, 0, 1, 4'hC, 32'h0,        4'h0, 32'h0,        32'hFFFF8001, 3};
        vecs[5]  = '{1'b0, 32'h0000_0003, 32'h0,        2'd1, 1'b1, 32'hAB000000, 32'h000000CD, 0, 0, 2, 4'h8, 32'h0,        4'h1, 32'h0,        32'h0000CDAB, 5};
        vecs[6]  = '{1'b0, 32'h0000_0101, 32'h0,        2'd2, 1'b0, 32'h44332211, 32'h88776655, 0, 0, 2, 4'hE, 32'h0,        4'h1, 32'h0,        32'h55443322, 5};
        vecs[7]  = '{1'b1, 32'h0000_0301, 32'h123456EF, 2'd0, 1'b0, 32'h0,        32'h0,        1, 0, 1, 4'h2, 32'h3456EF00, 4'h0, 32'h0,        32'h0,        -1};
        vecs[8]  = '{1'b1, 32'h0000_0400, 32'hFFFF5A5A, 2'd1, 1'b0, 32'h0,        32'h0,        0, 2, 1, 4'h3, 32'hFFFF5A5A, 4'h0, 32'h0,        32'h0,        -1};
        vecs[9]  = '{1'b0, 32'h0000_0500, 32'h0,        2'd3, 1'b0, 32'h7FFFFFFF, 32'h0,        2, 1, 1, 4'hF, 32'h0,        4'h0, 32'h0,        32'h7FFFFFFF, -1};
        vecs[10] = '{1'b0, 32'h0000_0600, 32'h0,        2'd0, 1'b0, 32'h0000007F, 32'h0,        0, 0, 1, 4'h1, 32'h0,        4'h0, 32'h0,        32'h0000007F, 3};
        vecs[11] = '{1'b1, 32'h0000_0703, 32'h11223344, 2'd2, 1'b0, 32'h0,        32'h0,        1, 1, 2, 4'h8, 32'h44000000, 4'h7, 32'h00112233, 32'h0,        -1};
        vecs[12] = '{1'b0, 32'h0000_0001, 32'h0,        2'd1, 1'b0, 32'h00FEDC00, 32'h0,        0, 0, 1, 4'h6, 32'h0,        4'h0, 32'h0,        32'hFFFFFEDC, 3};

        repeat (3) @(negedge clk);
        checkOutput("rstStall", {31'h0, stall}, 32'h0);
        checkOutput("rstBusReq", {31'h0, busReq}, 32'h0);
        checkOutput("rstLoadDone", {31'h0, loadDone}, 32'h0);
        checkOutput("rstMisalign", {31'h0, misalignErr}, 32'h0);
        checkOutput("rstLoadData", dmLoadData, 32'h0);
        checkOutput("rstBusAddr", busAddr, 32'h0);
        checkOutput("rstBusBe", {28'h0, busBe}, 32'h0);
        checkOutput("rstBusWData", busWData, 32'h0);
        checkOutput("rstNsStall", {31'h0, nsStall}, 32'h0);
        rst = 1'b0;
        responderOn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
        end

        // Non-splitting instance: crossing halfword is rejected, aligned one would stall.
        @(negedge clk);
        nsMemReq = 1'b1; memWe = 1'b0; memAddr = 32'h0000_0003; memSize = 2'd1; memUnsigned = 1'b0;
        #1;
        checkOutput("nsRejectStall", {31'h0, nsStall}, 32'h0);
        checkOutput("nsRejectBusReq", {31'h0, nsBusReq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        nsMemReq = 1'b0;
        checkOutput("nsMisalignPulse", {31'h0, nsMisalignErr}, 32'h1);
        checkOutput("nsBusReqAfter", {31'h0, nsBusReq}, 32'h0);
        checkOutput("nsStallAfter", {31'h0, nsStall}, 32'h0);
        @(negedge clk);
        checkOutput("nsMisalignEnd", {31'h0, nsMisalignErr}, 32'h0);
        nsMemReq = 1'b1; memAddr = 32'h0000_0002;
        #1 checkOutput("nsAlignedStall", {31'h0, nsStall}, 32'h1);
        nsMemReq = 1'b0;

        // Reset while waiting in RSP0, then a late response that must be dropped.
        @(negedge clk);
        responderOn = 1'b0;
        busGnt = 1'b1; busRValid = 1'b0;
        memReq = 1'b1; memWe = 1'b0; memAddr = 32'h0000_0800; memSize = 2'd2; memUnsigned = 1'b0; memWData = 32'h0;
        @(posedge clk);
        @(negedge clk);
        memReq = 1'b0;
        checkOutput("rstSeqBusReq", {31'h0, busReq}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstSeqStallRsp0", {31'h0, stall}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstStall", {31'h0, stall}, 32'h0);
        checkOutput("midRstBusReq", {31'h0, busReq}, 32'h0);
        checkOutput("midRstLoadData", dmLoadData, 32'h0);
        checkOutput("midRstBusAddr", busAddr, 32'h0);
        checkOutput("midRstBusBe", {28'h0, busBe}, 32'h0);
        busRValid = 1'b1; busRData = 32'h12345678;
        @(negedge clk);
        busRValid = 1'b0;
        checkOutput("lateRspStall", {31'h0, stall}, 32'h0);
        checkOutput("lateRspLoadDone", {31'h0, loadDone}, 32'h0);
        checkOutput("lateRspLoadData", dmLoadData, 32'h0);
        @(negedge clk);
        checkOutput("lateRspLoadDone2", {31'h0, loadDone}, 32'h0);
        lastLoad = 32'h0;
        responderOn = 1'b1;

        lastVec = '{1'b0, 32'h0000_0900, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0, 0, 0, 1, 4'hF, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D, 3};
        applyStimulus(lastVec);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
